// File: rtl/wmem_loader.sv
// Stream-to-memory loader: packs a valid/ready word stream into pairwise writes
// on both ports of a dual-port RAM, so word k always lands at address k.
module wmem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_num_words,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_a1,
    output logic [ADDR_W-1:0] o_a2,
    output logic              o_csb1,
    output logic              o_csb2,
    output logic              o_web1,
    output logic              o_web2,
    output logic              o_oeb1,
    output logic              o_oeb2,
    output logic [DATA_W-1:0] o_i1,
    output logic [DATA_W-1:0] o_i2
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_V = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_hold;
    logic              r_done;
    logic              r_csb1;
    logic              r_csb2;
    logic [ADDR_W-1:0] r_a1;
    logic [ADDR_W-1:0] r_a2;
    logic [DATA_W-1:0] r_i1;
    logic [DATA_W-1:0] r_i2;

    logic [ADDR_W:0]   w_len;
    logic              w_hs;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_len  = (i_num_words > DEPTH_V) ? DEPTH_V : i_num_words;
    assign w_hs   = i_in_valid && (r_state == S_FILL);
    assign w_last = (r_cnt == (r_len - ONE_L));
    assign w_addr = r_cnt[ADDR_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
            r_csb1  <= 1'b1;
            r_csb2  <= 1'b1;
            r_a1    <= '0;
            r_a2    <= '0;
            r_i1    <= '0;
            r_i2    <= '0;
        end else begin
            // Strobes are single-cycle: pins fall back to idle unless re-armed below.
            r_done <= 1'b0;
            r_csb1 <= 1'b1;
            r_csb2 <= 1'b1;
            r_a1   <= '0;
            r_a2   <= '0;
            r_i1   <= '0;
            r_i2   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len <= w_len;
                        r_cnt <= '0;
                        if (w_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + ONE_L;
                        if (!r_cnt[0]) begin
                            r_hold <= i_in_data;
                            if (w_last) begin
                                r_csb1 <= 1'b0;
                                r_a1   <= w_addr;
                                r_i1   <= i_in_data;
                            end
                        end else begin
                            r_csb1 <= 1'b0;
                            r_csb2 <= 1'b0;
                            r_a1   <= w_addr - ONE_A;
                            r_i1   <= r_hold;
                            r_a2   <= w_addr;
                            r_i2   <= i_in_data;
                        end
                        if (w_last) begin
                            r_state <= S_LAST;
                        end
                    end
                end
                S_LAST: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready = (r_state == S_FILL);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_a1       = r_a1;
    assign o_a2       = r_a2;
    assign o_i1       = r_i1;
    assign o_i2       = r_i2;
    assign o_csb1     = r_csb1;
    assign o_csb2     = r_csb2;
    assign o_web1     = r_csb1;
    assign o_web2     = r_csb2;
    assign o_oeb1     = 1'b1;
    assign o_oeb2     = 1'b1;

endmodule

// File: tb/tb_wmem_loader.sv
// Scoreboard bench for wmem_loader: the driver queues expected write strobes,
// a negedge monitor pops and compares every strobe it sees on the memory pins.
module tb_wmem_loader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [5:0]  i_num_words;
    logic        i_in_valid;
    logic [31:0] i_in_data;
    logic        o_in_ready, o_busy, o_done;
    logic [4:0]  o_a1, o_a2;
    logic        o_csb1, o_csb2, o_web1, o_web2, o_oeb1, o_oeb2;
    logic [31:0] o_i1, o_i2;

    wmem_loader #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_num_words(i_num_words),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_busy(o_busy), .o_done(o_done), .o_a1(o_a1), .o_a2(o_a2),
        .o_csb1(o_csb1), .o_csb2(o_csb2), .o_web1(o_web1), .o_web2(o_web2),
        .o_oeb1(o_oeb1), .o_oeb2(o_oeb2), .o_i1(o_i1), .o_i2(o_i2)
    );

    typedef struct packed {
        logic        p2;
        logic [4:0]  a1;
        logic [31:0] i1;
        logic [4:0]  a2;
        logic [31:0] i2;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          strobe_cnt = 0;
    logic [31:0] cyc = 0;
    logic [31:0] mem [32];
    int          wr_cnt [32];
    logic [31:0] prev_cyc = 32'hFFFF_FFFF;
    logic [4:0]  prev_a1 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the queue, in the expected cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("oeb_high", {30'd0, o_oeb1, o_oeb2}, 32'd3);
            if (!o_csb1) begin
                strobe_cnt++;
                chk("web1_eq_csb1", {31'd0, o_web1}, 32'd0);
                chk("web2_eq_csb2", {31'd0, o_web2}, {31'd0, o_csb2});
                if (prev_cyc + 1 == cyc)
                    chk("consec_addr_differs", {31'd0, prev_a1 == o_a1}, 32'd0);
                prev_cyc = cyc;
                prev_a1  = o_a1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe_a1", {27'd0, o_a1}, 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("csb2", {31'd0, o_csb2}, {31'd0, ~e.p2});
                    chk("a1", {27'd0, o_a1}, {27'd0, e.a1});
                    chk("i1", o_i1, e.i1);
                    if (e.p2) begin
                        chk("a2", {27'd0, o_a2}, {27'd0, e.a2});
                        chk("i2", o_i2, e.i2);
                    end
                end
                mem[o_a1] = o_i1;
                wr_cnt[o_a1]++;
                if (!o_csb2) begin
                    mem[o_a2] = o_i2;
                    wr_cnt[o_a2]++;
                end
            end else begin
                chk("idle_pins", {o_csb2, o_web1, o_web2, 29'd0}, 32'hE000_0000);
                chk("idle_addr_data", {22'd0, o_a1, o_a2} | o_i1 | o_i2, 32'd0);
            end
        end
    end

    task automatic load(input int n, input int gap_pct, input int restart_at, input logic [31:0] base);
        int len;
        int k;
        int guard;
        int s0;
        logic hs;
        len   = (n > 32) ? 32 : n;
        k     = 0;
        guard = 0;
        s0    = strobe_cnt;
        for (int j = 0; j < 32; j++) wr_cnt[j] = 0;
        i_start = 1'b1;
        i_num_words = n[5:0];
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        if (len == 0) begin
            chk("len0_done", {31'd0, o_done}, 32'd1);
            chk("len0_in_ready", {31'd0, o_in_ready}, 32'd0);
            @(posedge clk); #1;
            chk("len0_idle", {30'd0, o_busy, o_done}, 32'd0);
            chk("len0_no_strobes", strobe_cnt - s0, 32'd0);
            return;
        end
        while (k < len && guard < 2000) begin
            guard++;
            i_in_valid = ($urandom_range(99) >= gap_pct);
            i_in_data  = base + k;
            if (restart_at == k) begin
                i_start = 1'b1;
                i_num_words = 6'd3;
            end
            chk("in_ready_fill", {31'd0, o_in_ready}, 32'd1);
            hs = i_in_valid && o_in_ready;
            @(posedge clk); #1;
            if (hs) begin
                if (k % 2 == 1)
                    exp_q.push_back({1'b1, 5'(k - 1), base + k - 1, 5'(k), base + k, cyc});
                else if (k == len - 1)
                    exp_q.push_back({1'b0, 5'(k), base + k, 5'd0, 32'd0, cyc});
                k++;
            end
            i_in_valid = 1'b0;
            i_start    = 1'b0;
        end
        if (guard >= 2000) chk("load_timeout", 32'd1, 32'd0);
        chk("last_in_ready_low", {31'd0, o_in_ready}, 32'd0);
        chk("last_busy_nodone", {30'd0, o_busy, o_done}, 32'd2);
        @(posedge clk); #1;
        chk("done_pulse", {30'd0, o_busy, o_done}, 32'd3);
        @(posedge clk); #1;
        chk("idle_after_done", {30'd0, o_busy, o_done}, 32'd0);
        chk("strobe_count", strobe_cnt - s0, (len + 1) / 2);
        chk("queue_drained", exp_q.size(), 32'd0);
        for (int j = 0; j < len; j++) begin
            chk("readback", mem[j], base + j);
            chk("written_once", wr_cnt[j], 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        i_num_words = '0;
        i_in_valid = 1'b0;
        i_in_data = '0;
        for (int j = 0; j < 32; j++) mem[j] = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {28'd0, o_busy, o_done, o_in_ready, o_csb1}, 32'd1);
        chk("rst_pins", {27'd0, o_csb2, o_web1, o_web2, o_oeb1, o_oeb2}, 32'h1F);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // in_valid while idle must not load anything
        i_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        chk("idle_valid_ignored", {30'd0, o_busy, o_in_ready}, 32'd0);

        load(4, 0, -1, 32'hA0);
        chk("t1_word0", mem[0], 32'hA0);
        chk("t1_word3", mem[3], 32'hA3);
        load(5, 0, -1, 32'hB0);
        chk("t2_word4", mem[4], 32'hB4);
        load(32, 40, -1, 32'h1000);
        load(0, 0, -1, 32'h0);
        load(40, 0, -1, 32'h2000);
        load(6, 20, 2, 32'h3000);

        // Reset abandons a load after 3 of 8 words.
        i_start = 1'b1;
        i_num_words = 6'd8;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_in_valid = 1'b1;
            i_in_data = 32'h4000 + k;
            @(posedge clk); #1;
            if (k == 1) exp_q.push_back({1'b1, 5'd0, 32'h4000, 5'd1, 32'h4001, cyc});
        end
        i_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {29'd0, o_busy, o_in_ready, o_done}, 32'd0);
        chk("mid_rst_pins", {26'd0, o_csb1, o_csb2, o_web1, o_web2, o_oeb1, o_oeb2}, 32'h3F);
        chk("mid_rst_addr_data", {22'd0, o_a1, o_a2} | o_i1 | o_i2, 32'd0);
        chk("mid_rst_queue", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        load(2, 0, -1, 32'hC0);
        chk("post_rst_word0", mem[0], 32'hC0);
        chk("post_rst_word1", mem[1], 32'hC1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wmem_loader.md
# wmem_loader

Write-side companion to the neural-net controller: accepts a valid/ready stream of 32-bit words and writes them into one dpram32x32_cb instance (kernel or weight memory) through both ports, two words per clock. It drives the A/WEB/OEB/CSB/I pins of ports 1 and 2 directly and is the writer for memories the controller later reads during classify. One instance per memory; a top-level mux selects loader or controller ownership of the pins.

## Interface
- ADDR_W, 5, memory address width
- DATA_W, 32, word width
- DEPTH, 32, memory depth in words (2**ADDR_W)

- clk  in  1  clock; also tied to CEB1/CEB2 of the memory at top level
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle load request
- num_words  in  ADDR_W+1  words to load, sampled with start
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts in_data this cycle
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- A1, A2  out  ADDR_W  port 1 / port 2 addresses
- CSB1, CSB2  out  1  chip select, active-low
- WEB1, WEB2  out  1  write enable, active-low
- OEB1, OEB2  out  1  output enable, active-low; held 1 (never asserted)
- I1, I2  out  DATA_W  write data

## Operation
- States: IDLE, FILL, LAST, DONE. busy = (state != IDLE).
- IDLE: in_ready=0, memory pins idle. On start: len = min(num_words, DEPTH); len=0 -> DONE directly; else cnt=0, -> FILL.
- start outside IDLE ignored; in_valid in IDLE ignored.
- FILL: in_ready=1. Handshake = in_valid & in_ready; each increments cnt.
  - Word with even index cnt: captured in hold register, no write.
  - Word with odd index cnt: next cycle drives pair write: A1=cnt-1, I1=hold, A2=cnt, I2=in_data, CSB1=CSB2=WEB1=WEB2=0.
  - Handshake of word index len-1 -> LAST; in_ready=0 from next cycle.
- LAST (1 cycle): drives final write. Even len: pair write as above. Odd len: port 1 only (A1=len-1, I1=in_data), CSB2=WEB2=1.
- DONE (1 cycle): done=1, pins idle, -> IDLE.
- Word k always lands at address k; words never reorder or drop.
- Idle pin values: CSB*=1, WEB*=1, OEB*=1, A*=0, I*=0.
- Cycles without a write strobe drive idle pin values; A/I need not hold previous values.

## Timing
- Reset (rst=0, async): state=IDLE, in_ready=0, busy=0, done=0, all memory pins idle; hold and cnt cleared. Reset mid-load abandons the load; any strobe in flight is deasserted immediately; words already written remain in memory.
- All outputs registered except in_ready (decoded from state).
- Handshake at edge N -> write strobes active during cycle N..N+1 (one cycle); memory captures at edge N+1.
- Strobes are exactly one cycle wide; never two consecutive cycles on the same address.
- Throughput: one word per cycle with in_valid held high; len words occupy len cycles in FILL.
- start at edge S: busy=1 from S; full-rate load of len words: last handshake at edge S+len, LAST during next cycle, done=1 during cycle after that; busy falls with done.
- len=0: done=1 in cycle after start, no write strobes.
- in_valid gaps in FILL: loader waits, hold retained, no strobe issued.
- num_words > DEPTH clamped to DEPTH (32).

## Test plan
- start, num_words=4, words 0xA0..0xA3 back-to-back -> two pair writes: (A1=0,I1=0xA0,A2=1,I2=0xA1) then (A1=2,A2=3); done 1 cycle after second strobe; readback matches.
- num_words=5, 0xB0..0xB4 -> two pair writes, then port-1-only write A1=4,I1=0xB4 with CSB2=WEB2=1; OEB1/OEB2=1 throughout.
- num_words=32 with random in_valid gaps -> exactly 16 strobes, addresses 0..31 each written once, no strobe in gap cycles, memory readback matches.
- num_words=0 and num_words=40 -> first: done next cycle, no strobes; second: clamped, 32 words loaded, in_ready drops after 32nd handshake.
- start pulsed during FILL -> ignored, len/cnt unchanged, load completes normally.
- rst low after 3 of 8 words -> all pins idle immediately, busy=0, in_ready=0; new start of 2 words afterwards writes addresses 0,1 correctly.
